// File: rtl/mcycle_unit.sv
// Iterative multiply/divide engine: one shift-add (mul) or restoring shift-subtract (div)
// step per cycle over WIDTH cycles. Busy stalls the pipeline and Done pulses when results are written.
module mcycle_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Start,
  input  logic [1:0]       MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy,
  output logic             Done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Handshake: Start is a request that is accepted on the rising edge whenever the
  // engine is in sIdle or sDone; Busy is high from the request cycle until the Done cycle.
  typedef enum logic [1:0] {
    sIdle    = 2'd0,
    sCompute = 2'd1,
    sDone    = 2'd2
  } stateT;

  stateT            state;
  logic [CW-1:0]    count;
  logic             isDiv;
  logic             negRes;
  logic             negRem;
  logic             divZero;
  logic [WIDTH-1:0] op1Q;
  logic [WIDTH-1:0] magB;
  logic [WIDTH-1:0] hiQ;
  logic [WIDTH-1:0] loQ;

  // Operand magnitudes at capture time; signed ops have MCycleOp[0] == 0.
  logic             signedOp;
  logic             aNeg;
  logic             bNeg;
  logic [WIDTH-1:0] magA;
  logic [WIDTH-1:0] magBIn;

  assign signedOp = ~MCycleOp[0];
  assign aNeg     = signedOp & Operand1[WIDTH-1];
  assign bNeg     = signedOp & Operand2[WIDTH-1];
  assign magA     = aNeg ? -Operand1 : Operand1;
  assign magBIn   = bNeg ? -Operand2 : Operand2;

  // hiQ/loQ hold {partial product, multiplier} for mul and {remainder, dividend/quotient} for div.
  logic [WIDTH:0]   mulSum;
  logic [WIDTH:0]   divShift;
  logic [WIDTH:0]   divTrial;
  logic [WIDTH-1:0] nextHi;
  logic [WIDTH-1:0] nextLo;

  assign mulSum   = {1'b0, hiQ} + {1'b0, (loQ[0] ? magB : {WIDTH{1'b0}})};
  assign divShift = {hiQ, loQ[WIDTH-1]};
  assign divTrial = divShift - {1'b0, magB};

  always_comb begin
    nextHi = hiQ;
    nextLo = loQ;
    if (isDiv) begin
      if (!divTrial[WIDTH]) begin
        nextHi = divTrial[WIDTH-1:0];
        nextLo = {loQ[WIDTH-2:0], 1'b1};
      end else begin
        nextHi = divShift[WIDTH-1:0];
        nextLo = {loQ[WIDTH-2:0], 1'b0};
      end
    end else begin
      nextHi = mulSum[WIDTH:1];
      nextLo = {mulSum[0], loQ[WIDTH-1:1]};
    end
  end

  // Sign fix-up applied to the last iteration's output as it is written to Result1/Result2.
  logic [2*WIDTH-1:0] prodMag;
  logic [2*WIDTH-1:0] prodSigned;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   remOut;
  logic [WIDTH-1:0]   finRes1;
  logic [WIDTH-1:0]   finRes2;

  assign prodMag    = {nextHi, nextLo};
  assign prodSigned = negRes ? -prodMag : prodMag;
  assign quo        = negRes ? -nextLo : nextLo;
  assign remOut     = negRem ? -nextHi : nextHi;

  always_comb begin
    finRes1 = prodSigned[WIDTH-1:0];
    finRes2 = prodSigned[2*WIDTH-1:WIDTH];
    if (isDiv) begin
      if (divZero) begin
        finRes1 = {WIDTH{1'b1}};
        finRes2 = op1Q;
      end else begin
        finRes1 = quo;
        finRes2 = remOut;
      end
    end
  end

  assign Busy = (Start && (state == sIdle || state == sDone)) || (state == sCompute);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state   <= sIdle;
      count   <= '0;
      Result1 <= '0;
      Result2 <= '0;
      Done    <= 1'b0;
      isDiv   <= 1'b0;
      negRes  <= 1'b0;
      negRem  <= 1'b0;
      divZero <= 1'b0;
      op1Q    <= '0;
      magB    <= '0;
      hiQ     <= '0;
      loQ     <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        sIdle, sDone: begin
          if (Start) begin
            state   <= sCompute;
            count   <= '0;
            isDiv   <= MCycleOp[1];
            negRes  <= aNeg ^ bNeg;
            negRem  <= aNeg;
            divZero <= (Operand2 == '0);
            op1Q    <= Operand1;
            hiQ     <= '0;
            magB    <= MCycleOp[1] ? magBIn : magA;
            loQ     <= MCycleOp[1] ? magA : magBIn;
          end else begin
            state <= sIdle;
          end
        end
        sCompute: begin
          hiQ <= nextHi;
          loQ <= nextLo;
          if (count == CW'(WIDTH - 1)) begin
            Result1 <= finRes1;
            Result2 <= finRes2;
            Done    <= 1'b1;
            state   <= sDone;
          end else begin
            count <= count + CW'(1);
          end
        end
        default: state <= sIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mcycle_unit.sv
// Bench for mcycle_unit: directed and random ops, Start-hold, back-to-back and reset abort,
// with expected {Result2, Result1} queued at issue and checked when Done pulses.
module tb_mcycle_unit;

  localparam int W = 32;

  logic           CLK = 1'b0;
  logic           RESET = 1'b0;
  logic           Start = 1'b0;
  logic [1:0]     MCycleOp = 2'd0;
  logic [W-1:0]   Operand1 = '0;
  logic [W-1:0]   Operand2 = '0;
  logic [W-1:0]   Result1;
  logic [W-1:0]   Result2;
  logic           Busy;
  logic           Done;

  int             vectors = 0;
  int             miscompares = 0;
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] mon_e;

  mcycle_unit #(.WIDTH(W)) dut (
    .CLK(CLK), .RESET(RESET), .Start(Start), .MCycleOp(MCycleOp),
    .Operand1(Operand1), .Operand2(Operand2),
    .Result1(Result1), .Result2(Result2), .Busy(Busy), .Done(Done)
  );

  // clock / reset block
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard: pop the oldest expectation whenever Done is seen
  always @(negedge CLK) begin
    if (RESET && Done === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_done got R2=%h R1=%h required no Done", Result2, Result1);
      end else begin
        mon_e = exp_q.pop_front();
        if ({Result2, Result1} !== mon_e) begin
          miscompares++;
          $display("FAIL result got R2=%h R1=%h required R2=%h R1=%h",
                   Result2, Result1, mon_e[2*W-1:W], mon_e[W-1:0]);
        end
      end
    end
  end

  function automatic logic [2*W-1:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic signed [2*W-1:0] sa, sb;
    logic [W-1:0] q, r;
    model = '0;
    case (op)
      2'd0: begin
        sa = {{W{a[W-1]}}, a};
        sb = {{W{b[W-1]}}, b};
        model = sa * sb;
      end
      2'd1: model = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      default: begin
        if (b == '0) model = {a, {W{1'b1}}};
        else if (op == 2'd3) model = {a % b, a / b};
        else if (a == {1'b1, {(W-1){1'b0}}} && b == {W{1'b1}}) model = {{W{1'b0}}, a};
        else begin
          q = $signed(a) / $signed(b);
          r = $signed(a) % $signed(b);
          model = {r, q};
        end
      end
    endcase
  endfunction

  // driver: one-cycle Start, expectation queued, operands scrambled afterwards
  task automatic apply_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] e);
    @(negedge CLK);
    Start = 1'b1; MCycleOp = op; Operand1 = a; Operand2 = b;
    exp_q.push_back(e);
    #1;
    vectors++;
    if (Busy !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_on_start got %b required 1", Busy);
    end
    @(posedge CLK);
    #1;
    Start = 1'b0;
    Operand1 = $urandom; Operand2 = $urandom; MCycleOp = 2'($urandom_range(0, 3));
  endtask

  // cyc = cycles after the accepting edge until Done (-1 on timeout)
  task automatic wait_done(output int cyc, output bit busy_bad);
    cyc = -1;
    busy_bad = 1'b0;
    for (int n = 0; n <= 3 * W; n++) begin
      @(negedge CLK);
      if (Done === 1'b1) begin
        cyc = n;
        if (Busy !== 1'b0) busy_bad = 1'b1;
        break;
      end
      if (Busy !== 1'b1) busy_bad = 1'b1;
    end
  endtask

  task automatic test_reset;
    #2;
    vectors++;
    if ({Result2, Result1, Done, Busy} !== {(2*W+2){1'b0}}) begin
      miscompares++;
      $display("FAIL reset_state got R2=%h R1=%h Done=%b Busy=%b required all 0",
               Result2, Result1, Done, Busy);
    end
    @(negedge CLK);
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_directed;
    logic [1:0]     ops[10];
    logic [W-1:0]   as[10];
    logic [W-1:0]   bs[10];
    logic [2*W-1:0] es[10];
    int cyc;
    bit bb;
    ops[0] = 2'b01; as[0] = 32'hFFFFFFFF; bs[0] = 32'hFFFFFFFF; es[0] = 64'hFFFFFFFE_00000001;
    ops[1] = 2'b00; as[1] = -32'sd3;      bs[1] = 32'd7;        es[1] = 64'hFFFFFFFF_FFFFFFEB;
    ops[2] = 2'b10; as[2] = -32'sd7;      bs[2] = 32'd2;        es[2] = 64'hFFFFFFFF_FFFFFFFD;
    ops[3] = 2'b11; as[3] = 32'd100;      bs[3] = 32'd7;        es[3] = 64'h00000002_0000000E;
    ops[4] = 2'b11; as[4] = 32'h1234;     bs[4] = 32'd0;        es[4] = 64'h00001234_FFFFFFFF;
    ops[5] = 2'b10; as[5] = 32'h80000000; bs[5] = 32'hFFFFFFFF; es[5] = 64'h00000000_80000000;
    ops[6] = 2'b10; as[6] = 32'hFFFFFF00; bs[6] = 32'd0;        es[6] = 64'hFFFFFF00_FFFFFFFF;
    ops[7] = 2'b10; as[7] = 32'd7;        bs[7] = -32'sd2;      es[7] = 64'h00000001_FFFFFFFD;
    ops[8] = 2'b00; as[8] = 32'h80000000; bs[8] = 32'h80000000; es[8] = 64'h40000000_00000000;
    ops[9] = 2'b00; as[9] = 32'h80000000; bs[9] = 32'd1;        es[9] = 64'hFFFFFFFF_80000000;
    for (int i = 0; i < 10; i++) begin
      apply_op(ops[i], as[i], bs[i], es[i]);
      wait_done(cyc, bb);
      vectors++;
      if (cyc !== W) begin
        miscompares++;
        $display("FAIL latency_directed_%0d got %0d required %0d", i, cyc, W);
      end
      vectors++;
      if (bb) begin
        miscompares++;
        $display("FAIL busy_directed_%0d got glitch required high until Done", i);
      end
    end
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0: pick_operand = 32'h80000000;
      1: pick_operand = 32'hFFFFFFFF;
      2: pick_operand = '0;
      3: pick_operand = W'($urandom_range(0, 20));
      default: pick_operand = $urandom;
    endcase
  endfunction

  task automatic test_random;
    logic [1:0] op;
    logic [W-1:0] a, b;
    int cyc;
    bit bb;
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      a = pick_operand();
      b = pick_operand();
      apply_op(op, a, b, model(op, a, b));
      wait_done(cyc, bb);
      vectors++;
      if (cyc !== W || bb) begin
        miscompares++;
        $display("FAIL timing_random_%0d got cyc=%0d busy_bad=%b required cyc=%0d busy_bad=0",
                 i, cyc, bb, W);
      end
    end
  endtask

  task automatic test_start_hold;
    @(negedge CLK);
    Start = 1'b1; MCycleOp = 2'b00; Operand1 = -32'sd1000; Operand2 = 32'd12345;
    exp_q.push_back(model(2'b00, -32'sd1000, 32'd12345));
    @(posedge CLK);
    for (int n = 0; n < W; n++) begin
      @(negedge CLK);
      vectors++;
      if (Done !== 1'b0) begin
        miscompares++;
        $display("FAIL hold_early_done cycle %0d got %b required 0", n, Done);
      end
      Operand1 = $urandom; Operand2 = $urandom; MCycleOp = 2'($urandom_range(0, 3));
    end
    @(negedge CLK);
    Start = 1'b0;
    vectors++;
    if (Done !== 1'b1) begin
      miscompares++;
      $display("FAIL hold_done got %b required 1", Done);
    end
    repeat (3) @(negedge CLK);
    vectors++;
    if ({Result2, Result1} !== model(2'b00, -32'sd1000, 32'd12345)) begin
      miscompares++;
      $display("FAIL hold_results got %h_%h required %h", Result2, Result1,
               model(2'b00, -32'sd1000, 32'd12345));
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    bit bb;
    apply_op(2'b11, 32'd1000000, 32'd333, model(2'b11, 32'd1000000, 32'd333));
    wait_done(cyc, bb);
    vectors++;
    if (cyc !== W) begin
      miscompares++;
      $display("FAIL b2b_first_latency got %0d required %0d", cyc, W);
    end
    Start = 1'b1; MCycleOp = 2'b01; Operand1 = 32'hDEADBEEF; Operand2 = 32'h00C0FFEE;
    exp_q.push_back(model(2'b01, 32'hDEADBEEF, 32'h00C0FFEE));
    #1;
    vectors++;
    if (Busy !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_busy_in_done got %b required 1", Busy);
    end
    @(posedge CLK);
    #1;
    Start = 1'b0;
    wait_done(cyc, bb);
    vectors++;
    if (cyc !== W || bb) begin
      miscompares++;
      $display("FAIL b2b_second_timing got cyc=%0d busy_bad=%b required cyc=%0d", cyc, bb, W);
    end
  endtask

  task automatic test_reset_abort;
    int cyc;
    bit bb;
    apply_op(2'b01, 32'h0000FFFF, 32'h0000FFFF, model(2'b01, 32'h0000FFFF, 32'h0000FFFF));
    repeat (10) @(negedge CLK);
    RESET = 1'b0;
    exp_q.delete();
    #1;
    vectors++;
    if ({Result2, Result1, Done, Busy} !== {(2*W+2){1'b0}}) begin
      miscompares++;
      $display("FAIL abort_outputs got R2=%h R1=%h Done=%b Busy=%b required all 0",
               Result2, Result1, Done, Busy);
    end
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    for (int n = 0; n < 2 * W; n++) begin
      @(negedge CLK);
      vectors++;
      if (Done !== 1'b0) begin
        miscompares++;
        $display("FAIL abort_spurious_done cycle %0d got %b required 0", n, Done);
      end
    end
    apply_op(2'b10, -32'sd100, 32'd9, model(2'b10, -32'sd100, 32'd9));
    wait_done(cyc, bb);
    vectors++;
    if (cyc !== W || bb) begin
      miscompares++;
      $display("FAIL abort_restart_timing got cyc=%0d busy_bad=%b required cyc=%0d", cyc, bb, W);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_hold();
    test_back_to_back();
    test_reset_abort();
    repeat (3) @(negedge CLK);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL leftover_expected got %0d entries required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
